rptr_empty_level: RTL and testbench

//  - Read-domain pointer/flag block for the async FIFO; next generation of the read-pointer/empty logic.
//  - Adds a registered read-side fill level, a programmable almost-empty flag and a sticky underflow error.
//  - Sits in the rclk domain, between the wptr 2-FF synchroniser (rq2_wptr) and the dual-port RAM read port.

---
 rtl/fifo_ptr_pkg.sv | 26 ++
 rtl/fifo_gray2bin.sv | 19 +
 rtl/rptr_empty_level.sv | 127 ++++++++++++
 tb/tb_rptr_empty_level.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Purpose : shared pointer helpers for the async FIFO read/write pointer blocks.
// Contents: PTR_MAX_W  - widest pointer the helpers handle
//           bin2gray() - binary to reflected Gray
//           gray2bin() - reflected Gray to binary
// Callers zero-extend narrower pointers to PTR_MAX_W and cast the result back
// to their own width; zero-extension leaves both codes unchanged.
package fifo_ptr_pkg;

    localparam int unsigned PTR_MAX_W = 16;

    // Binary to Gray: each bit XORed with its upper neighbour.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: bit k is the XOR of all Gray bits at or above k.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < int'(PTR_MAX_W); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Purpose : combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Ports   : gray in  [W-1:0]  Gray-coded pointer
//           bin  out [W-1:0]  binary equivalent
module fifo_gray2bin #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // bin[i] is the reduction XOR of gray[W-1:i].
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(W); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_level.sv
// Purpose : read-domain pointer and flag block of the async FIFO. Keeps the
//           binary/Gray read pointer, the registered empty flag, the read-side
//           fill level, a programmable almost-empty flag and a sticky underflow.
// Ports   : rclk        in   read clock
//           rrst_n      in   asynchronous reset, active-high
//           rinc        in   pop request (ignored while rempty)
//           rq2_wptr    in   [ADDRSIZE:0] write pointer, Gray, synchronised to rclk
//           ae_thresh   in   [ADDRSIZE:0] almost-empty threshold in words
//           rerr_clr    in   clears runderflow
//           raddr       out  [ADDRSIZE-1:0] RAM read address
//           rptr        out  [ADDRSIZE:0] read pointer, Gray, registered
//           rempty      out  FIFO empty, registered
//           raempty     out  level <= ae_thresh, registered
//           rlevel      out  [ADDRSIZE:0] words available, registered
//           runderflow  out  sticky pop-while-empty error
// Config  : `define RPTR_UNDERFLOW_ERR_EN to build the sticky underflow register;
//           otherwise runderflow is tied low and rerr_clr is ignored.
module rptr_empty_level
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 3,
    parameter bit          AE_RST   = 1'b1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [ADDRSIZE:0]   ae_thresh,
    input  logic                rerr_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin_q,    rbin_d;
    logic [PW-1:0] rptr_q,    rptr_d;
    logic          rempty_q,  rempty_d;
    logic          raempty_q, raempty_d;
    logic [PW-1:0] rlevel_q,  rlevel_d;
    logic [PW-1:0] rwbin;
    logic          pop;

    // Synchronised write pointer back to binary for the level subtraction.
    fifo_gray2bin #(
        .W (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (rwbin)
    );

    // Next pointer, empty compare and level; a pop and a write-pointer advance
    // in the same cycle both land in one level computation.
    always_comb begin
        pop       = 1'b0;
        rbin_d    = rbin_q;
        rptr_d    = rptr_q;
        rempty_d  = rempty_q;
        rlevel_d  = rlevel_q;
        raempty_d = raempty_q;

        pop       = rinc & ~rempty_q;
        rbin_d    = rbin_q + PW'(pop);
        rptr_d    = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
        rempty_d  = (rptr_d == rq2_wptr);
        // Modular difference stays correct across the wrap bit; max DEPTH.
        rlevel_d  = rwbin - rbin_d;
        raempty_d = (rlevel_d <= ae_thresh);
    end

    // Pointer and flag registers.
    always_ff @(posedge rclk or posedge rrst_n) begin
        if (rrst_n) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= AE_RST;
            rlevel_q  <= '0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            rlevel_q  <= rlevel_d;
        end
    end

    assign raddr   = rbin_q[ADDRSIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rlevel  = rlevel_q;

`ifdef RPTR_UNDERFLOW_ERR_EN
    logic runderflow_q, runderflow_d;

    // Sticky underflow; a new pop-while-empty beats a simultaneous clear.
    always_comb begin
        runderflow_d = runderflow_q;
        if (rerr_clr) begin
            runderflow_d = 1'b0;
        end
        if (rinc && rempty_q) begin
            runderflow_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rrst_n) begin
        if (rrst_n) begin
            runderflow_q <= 1'b0;
        end else begin
            runderflow_q <= runderflow_d;
        end
    end

    assign runderflow = runderflow_q;
`else
    logic unused_rerr_clr;
    assign unused_rerr_clr = rerr_clr;
    assign runderflow      = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_level.sv
// Bench for rptr_empty_level (ADDRSIZE=3, DEPTH=8): directed vectors with
// literal expectations plus a per-cycle comparison against a word-count model.
module tb_rptr_empty_level;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int NPTR  = 16;
    localparam bit AE_RS = 1'b1;

    logic          rclk;
    logic          rrst_n;
    logic          rinc;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] ae_thresh;
    logic          rerr_clr;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          rempty;
    logic          raempty;
    logic [PW-1:0] rlevel;
    logic          runderflow;

    int total = 0;
    int bad   = 0;

    rptr_empty_level #(
        .ADDRSIZE (AW),
        .AE_RST   (AE_RS)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .ae_thresh  (ae_thresh),
        .rerr_clr   (rerr_clr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

`ifdef RPTR_UNDERFLOW_ERR_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by search over all pointer values.
    function automatic int bin_of_gray(input int g);
        for (int b = 0; b < NPTR; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words read so far and words available, in plain counts.
    int m_rbin;
    int m_level;
    bit m_empty;
    bit m_aempty;
    bit m_uf;

    always @(posedge rclk or posedge rrst_n) begin
        int taken;
        int nb;
        int lvl;
        if (rrst_n) begin
            m_rbin   <= 0;
            m_level  <= 0;
            m_empty  <= 1'b1;
            m_aempty <= AE_RS;
            m_uf     <= 1'b0;
        end else begin
            taken    = (rinc && !m_empty) ? 1 : 0;
            nb       = (m_rbin + taken) % NPTR;
            lvl      = (bin_of_gray(int'(rq2_wptr)) + NPTR - nb) % NPTR;
            m_rbin   <= nb;
            m_level  <= lvl;
            m_empty  <= (lvl == 0);
            m_aempty <= (lvl <= int'(ae_thresh));
            if (UF_EN) begin
                if (rinc && m_empty) m_uf <= 1'b1;
                else if (rerr_clr)   m_uf <= 1'b0;
            end
        end
    end

    // Every-cycle comparison, sampled mid-period.
    always @(negedge rclk) begin
        chk("rptr",       int'(rptr),       gray_of(m_rbin));
        chk("raddr",      int'(raddr),      m_rbin % 8);
        chk("rempty",     int'(rempty),     int'(m_empty));
        chk("raempty",    int'(raempty),    int'(m_aempty));
        chk("rlevel",     int'(rlevel),     m_level);
        chk("runderflow", int'(runderflow), int'(m_uf));
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    int w_bin;
    int exp_addr [4];
    int exp_gray [4];

    initial begin
        exp_addr[0] = 6; exp_addr[1] = 7; exp_addr[2] = 0; exp_addr[3] = 1;
        exp_gray[0] = 4'b1000; exp_gray[1] = 4'b0000;
        exp_gray[2] = 4'b0001; exp_gray[3] = 4'b0011;

        rrst_n    = 1'b1;
        rinc      = 1'b0;
        rq2_wptr  = '0;
        ae_thresh = 4'd2;
        rerr_clr  = 1'b0;
        repeat (3) tick();
        rrst_n = 1'b0;
        tick();
        chk("rst_rptr",    int'(rptr),       0);
        chk("rst_rempty",  int'(rempty),     1);
        chk("rst_raempty", int'(raempty),    1);
        chk("rst_rlevel",  int'(rlevel),     0);

        // Fill to five words, then move the threshold around the level.
        rq2_wptr = 4'b0111;
        tick();
        chk("fill_rlevel",  int'(rlevel),  5);
        chk("fill_rempty",  int'(rempty),  0);
        chk("fill_raempty", int'(raempty), 0);
        ae_thresh = 4'd5;
        tick();
        chk("ae5_raempty", int'(raempty), 1);
        ae_thresh = 4'd4;
        tick();
        chk("ae4_raempty", int'(raempty), 0);

        // Reset while popping.
        rinc = 1'b1;
        repeat (2) tick();
        chk("pre_rst_raddr", int'(raddr), 2);
        rrst_n   = 1'b1;
        rinc     = 1'b0;
        rq2_wptr = '0;
        #1;
        chk("mid_rst_rptr",       int'(rptr),       0);
        chk("mid_rst_raddr",      int'(raddr),      0);
        chk("mid_rst_rempty",     int'(rempty),     1);
        chk("mid_rst_raempty",    int'(raempty),    1);
        chk("mid_rst_rlevel",     int'(rlevel),     0);
        chk("mid_rst_runderflow", int'(runderflow), 0);
        tick();
        rrst_n    = 1'b0;
        ae_thresh = 4'd2;
        tick();

        // Full level, then walk the read pointer to 14.
        rq2_wptr = 4'b1100;
        tick();
        chk("full_rlevel",  int'(rlevel),  8);
        chk("full_rempty",  int'(rempty),  0);
        chk("full_raempty", int'(raempty), 0);
        rinc = 1'b1;
        repeat (8) tick();
        rinc = 1'b0;
        chk("drain8_rempty", int'(rempty), 1);
        rq2_wptr = 4'(gray_of(14));
        tick();
        rinc = 1'b1;
        repeat (6) tick();
        rinc = 1'b0;
        chk("at14_rptr", int'(rptr), gray_of(14));

        // Four pops across the pointer wrap.
        rq2_wptr = 4'b0011;
        tick();
        chk("wrap_rlevel", int'(rlevel), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_raddr", int'(raddr), exp_addr[i]);
            rinc = 1'b1;
            tick();
            chk("wrap_rlevel", int'(rlevel), 3 - i);
            chk("wrap_rptr",   int'(rptr),   exp_gray[i]);
        end
        rinc = 1'b0;
        chk("wrap_rempty", int'(rempty), 1);

        // Underflow set, set-beats-clear, clear.
        rinc = 1'b1;
        tick();
        chk("uf_rptr",       int'(rptr),       4'b0011);
        chk("uf_set",        int'(runderflow), int'(UF_EN));
        rerr_clr = 1'b1;
        tick();
        chk("uf_set_wins",   int'(runderflow), int'(UF_EN));
        rinc = 1'b0;
        tick();
        chk("uf_clr",        int'(runderflow), 0);
        rerr_clr = 1'b0;

        // Pop and write advance in the same cycle at level 1.
        rq2_wptr = 4'(gray_of(3));
        tick();
        chk("conc_pre_level", int'(rlevel), 1);
        rinc     = 1'b1;
        rq2_wptr = 4'(gray_of(4));
        tick();
        rinc = 1'b0;
        chk("conc_rempty", int'(rempty), 0);
        chk("conc_rlevel", int'(rlevel), 1);
        tick();

        // Mixed traffic; writer never runs more than DEPTH ahead.
        w_bin = 4;
        for (int n = 0; n < 80; n++) begin
            rinc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1 && ((w_bin - m_rbin + NPTR) % NPTR) < 8)
                w_bin = (w_bin + 1) % NPTR;
            rq2_wptr = 4'(gray_of(w_bin));
            if (n % 10 == 0) ae_thresh = 4'($urandom_range(0, 8));
            rerr_clr = (n % 7 == 0);
            tick();
        end
        rinc     = 1'b0;
        rerr_clr = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
